// File: rtl/ball_motion.sv
// Single-ball motion engine: fixed-point position/velocity with frame-boundary reflection,
// serve/lost game states and paddle-driven vertical speed-up.
module ball_motion #(
    parameter int X_WIDTH       = 10,
    parameter int Y_WIDTH       = 9,
    parameter int FRAC_BITS     = 1,
    parameter int VEL_WIDTH     = 4,
    parameter int INITIAL_X     = 318,
    parameter int INITIAL_Y     = 450,
    parameter int INITIAL_VEL_X = 2,
    parameter int INITIAL_VEL_Y = -2,
    parameter int MAX_SPEED     = 6,
    parameter int SPEEDUP_HITS  = 4,
    parameter int LOST_Y        = 470
) (
    input  logic               clk,
    input  logic               nRst,
    input  logic               frame_pulse,
    input  logic               do_move,
    input  logic               serve,
    input  logic               collision,
    input  logic               ball_top_col,
    input  logic               ball_bottom_col,
    input  logic               ball_left_col,
    input  logic               ball_right_col,
    input  logic               paddle_col,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               ball_active,
    output logic               lost
);

    localparam int PX_W  = X_WIDTH + FRAC_BITS;
    localparam int PY_W  = Y_WIDTH + FRAC_BITS;
    localparam int CNT_W = $clog2(SPEEDUP_HITS + 1);

    localparam logic [PX_W-1:0]             INIT_PX    = PX_W'(INITIAL_X * (2 ** FRAC_BITS));
    localparam logic [PY_W-1:0]             INIT_PY    = PY_W'(INITIAL_Y * (2 ** FRAC_BITS));
    localparam logic signed [VEL_WIDTH-1:0] INIT_VX    = VEL_WIDTH'(INITIAL_VEL_X);
    localparam logic signed [VEL_WIDTH-1:0] INIT_VY    = VEL_WIDTH'(INITIAL_VEL_Y);
    localparam logic [VEL_WIDTH-1:0]        MAX_MAG    = VEL_WIDTH'(MAX_SPEED);
    localparam logic [CNT_W-1:0]            HITS_TOP   = CNT_W'(SPEEDUP_HITS);
    localparam logic [Y_WIDTH-1:0]          LOST_LIMIT = Y_WIDTH'(LOST_Y);

    typedef enum logic [1:0] {ST_SERVE, ST_MOVING, ST_LOST} state_t;

    state_t                      state, next_state;
    logic [PX_W-1:0]             pos_x, step_px;
    logic [PY_W-1:0]             pos_y, step_py;
    logic signed [VEL_WIDTH-1:0] vel_x, vel_y, refl_vx, refl_vy, sped_vy;
    logic [VEL_WIDTH-1:0]        mag, mag_up;
    logic [CNT_W-1:0]            hit_cnt, cnt_inc;
    logic                        latch_any, latch_v, latch_h, latch_pad, serve_pending;
    logic                        wrap_y, lost_hit, pad_hit, speedup;

    // Reflection and step use the latches gathered before this frame's clear.
    always_comb begin
        refl_vx = (latch_any && latch_h) ? -vel_x : vel_x;
        refl_vy = (latch_any && latch_v) ? -vel_y : vel_y;
        step_px = pos_x + PX_W'(refl_vx);
        step_py = pos_y + PY_W'(refl_vy);
        wrap_y   = refl_vy[VEL_WIDTH-1] ? (step_py > pos_y) : (step_py < pos_y);
        lost_hit = !wrap_y && (step_py[PY_W-1:FRAC_BITS] >= LOST_LIMIT);
        pad_hit  = latch_any && latch_pad;
        cnt_inc  = hit_cnt + CNT_W'(1);
        speedup  = pad_hit && (cnt_inc == HITS_TOP);
        mag      = refl_vy[VEL_WIDTH-1] ? -refl_vy : refl_vy;
        mag_up   = (mag >= MAX_MAG) ? MAX_MAG : mag + VEL_WIDTH'(1);
        sped_vy  = refl_vy[VEL_WIDTH-1] ? -$signed(mag_up) : $signed(mag_up);
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_SERVE:  if (frame_pulse && (serve_pending || serve)) next_state = ST_MOVING;
            ST_MOVING: if (frame_pulse && do_move && lost_hit)      next_state = ST_LOST;
            ST_LOST:   if (frame_pulse)                             next_state = ST_SERVE;
            default:   next_state = ST_SERVE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            state         <= ST_SERVE;
            pos_x         <= INIT_PX;
            pos_y         <= INIT_PY;
            vel_x         <= INIT_VX;
            vel_y         <= INIT_VY;
            hit_cnt       <= '0;
            latch_any     <= 1'b0;
            latch_v       <= 1'b0;
            latch_h       <= 1'b0;
            latch_pad     <= 1'b0;
            serve_pending <= 1'b0;
            lost          <= 1'b0;
        end else begin
            state         <= next_state;
            lost          <= (next_state == ST_LOST) && (state != ST_LOST);
            serve_pending <= (state == ST_SERVE) && (next_state == ST_SERVE) && (serve_pending || serve);

            // A collision arriving on the frame boundary cycle is deliberately lost.
            if (frame_pulse) begin
                latch_any <= 1'b0;
                latch_v   <= 1'b0;
                latch_h   <= 1'b0;
                latch_pad <= 1'b0;
            end else if (collision) begin
                latch_any <= 1'b1;
                latch_v   <= latch_v | ball_top_col | ball_bottom_col;
                latch_h   <= latch_h | ball_left_col | ball_right_col;
                latch_pad <= latch_pad | paddle_col;
            end

            case (state)
                ST_SERVE: begin
                    pos_x <= INIT_PX;
                    pos_y <= INIT_PY;
                    if (next_state == ST_MOVING) begin
                        vel_x <= INIT_VX;
                        vel_y <= INIT_VY;
                    end
                end
                ST_MOVING: begin
                    if (frame_pulse && do_move) begin
                        pos_x <= step_px;
                        pos_y <= step_py;
                        vel_x <= refl_vx;
                        vel_y <= speedup ? sped_vy : refl_vy;
                        if (pad_hit) hit_cnt <= speedup ? '0 : cnt_inc;
                    end
                end
                ST_LOST: begin
                    if (frame_pulse) begin
                        pos_x   <= INIT_PX;
                        pos_y   <= INIT_PY;
                        vel_x   <= INIT_VX;
                        vel_y   <= INIT_VY;
                        hit_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign x           = pos_x[PX_W-1:FRAC_BITS];
    assign y           = pos_y[PY_W-1:FRAC_BITS];
    assign ball_active = (state == ST_MOVING);

endmodule

// File: tb/tb_ball_motion.sv
// Scoreboard bench for ball_motion: a frame-level game model predicts x/y/active/lost after
// every frame pulse; a monitor compares once the DUT has taken that frame boundary.
module tb_ball_motion;

    logic       clk = 1'b0;
    logic       nRst = 1'b1;
    logic       frame_pulse = 1'b0, do_move = 1'b0, serve = 1'b0, collision = 1'b0;
    logic       top = 1'b0, bottom = 1'b0, left = 1'b0, right = 1'b0, paddle = 1'b0;
    logic [9:0] x;
    logic [8:0] y;
    logic       ball_active, lost;

    ball_motion dut (
        .clk(clk), .nRst(nRst), .frame_pulse(frame_pulse), .do_move(do_move), .serve(serve),
        .collision(collision), .ball_top_col(top), .ball_bottom_col(bottom),
        .ball_left_col(left), .ball_right_col(right), .paddle_col(paddle),
        .x(x), .y(y), .ball_active(ball_active), .lost(lost)
    );

    always #5 clk = ~clk;

    typedef struct {int ex; int ey; int act; int lst;} exp_t;
    exp_t sb[$];
    exp_t got;
    int   checks = 0, errors = 0;

    // Game model in half-pixel units; mode 0 = waiting for serve, 1 = in play, 2 = lost.
    int m_mode, m_px, m_py, m_vx, m_vy, m_hits;
    bit acc_v, acc_h, acc_pad, acc_serve;
    logic fp_seen;

    task automatic check_output(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_px = 636; m_py = 900; m_vx = 2; m_vy = -2; m_hits = 0;
        acc_v = 0; acc_h = 0; acc_pad = 0; acc_serve = 0;
    endtask

    task automatic model_frame(input bit dm);
        int raw_y, mag;
        bit wrapped, just_lost;
        just_lost = 0;
        if (m_mode == 0) begin
            if (acc_serve) begin
                m_mode = 1; m_vx = 2; m_vy = -2;
            end
        end else if (m_mode == 1) begin
            if (dm) begin
                if (acc_v) m_vy = -m_vy;
                if (acc_h) m_vx = -m_vx;
                m_px = ((m_px + m_vx) % 2048 + 2048) % 2048;
                raw_y = m_py + m_vy;
                wrapped = (raw_y < 0) || (raw_y >= 1024);
                m_py = (raw_y % 1024 + 1024) % 1024;
                if (acc_pad) begin
                    m_hits++;
                    if (m_hits == 4) begin
                        m_hits = 0;
                        mag = (m_vy < 0 ? -m_vy : m_vy) + 1;
                        if (mag > 6) mag = 6;
                        m_vy = (m_vy < 0) ? -mag : mag;
                    end
                end
                if (!wrapped && (m_py / 2) >= 470) begin
                    m_mode = 2; just_lost = 1;
                end
            end
        end else begin
            m_mode = 0; m_px = 636; m_py = 900; m_vx = 2; m_vy = -2; m_hits = 0;
        end
        sb.push_back('{m_px / 2, m_py / 2, (m_mode == 1) ? 1 : 0, just_lost ? 1 : 0});
        acc_v = 0; acc_h = 0; acc_pad = 0; acc_serve = 0;
    endtask

    // One clock cycle of stimulus; a frame cycle also advances the model.
    task automatic cycle(input bit fp, input bit dm, input bit s, input bit c,
                         input bit t, input bit b, input bit l, input bit r, input bit p);
        @(posedge clk); #1;
        frame_pulse = fp; do_move = dm; serve = s; collision = c;
        top = t; bottom = b; left = l; right = r; paddle = p;
        acc_serve |= s;
        if (fp) model_frame(dm);
        else if (c) begin
            acc_v |= t | b; acc_h |= l | r; acc_pad |= p;
        end
    endtask

    task automatic quiet_frame(input bit dm);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, dm, 0, 0, 0, 0, 0, 0, 0);
    endtask

    always @(posedge clk or negedge nRst)
        if (!nRst) fp_seen <= 1'b0;
        else       fp_seen <= frame_pulse;

    initial begin
        forever begin
            @(negedge clk);
            if (nRst) begin
                if (fp_seen) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("[TB] FAIL unexpected_frame: got a frame output, expected empty queue");
                    end else begin
                        got = sb.pop_front();
                        check_output("frame_x", int'(x), got.ex);
                        check_output("frame_y", int'(y), got.ey);
                        check_output("frame_active", int'(ball_active), got.act);
                        check_output("frame_lost", int'(lost), got.lst);
                    end
                end else begin
                    check_output("lost_idle", int'(lost), 0);
                end
            end
        end
    end

    initial begin
        int n;
        bit s, c;
        #2 nRst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_output("reset_x", int'(x), 318);
        check_output("reset_y", int'(y), 450);
        check_output("reset_active", int'(ball_active), 0);
        check_output("reset_lost", int'(lost), 0);
        @(negedge clk); nRst = 1'b1;

        repeat (3) quiet_frame(1);
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        quiet_frame(1);

        cycle(0, 1, 0, 1, 1, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 1, 1, 0, 0, 0, 0);

        cycle(0, 1, 0, 1, 1, 0, 0, 0, 0);
        cycle(0, 1, 0, 1, 0, 0, 1, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        quiet_frame(0);

        repeat (16) begin
            cycle(0, 1, 0, 1, 0, 1, 0, 0, 1);
            cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        end

        for (int i = 0; i < 1000 && m_mode != 2; i++) quiet_frame(1);
        quiet_frame(0);
        quiet_frame(1);

        for (int f = 0; f < 300; f++) begin
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                s = (m_mode == 0) && ($urandom_range(0, 3) == 0);
                c = ($urandom_range(0, 3) == 0);
                cycle(0, 1, s, c, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            end
            s = (m_mode == 0) && ($urandom_range(0, 3) == 0);
            cycle(1, ($urandom_range(0, 5) != 0), s, 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom), 1'($urandom), 1'($urandom));
        end

        if (m_mode == 2) quiet_frame(1);
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        quiet_frame(1);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #2;
        nRst = 1'b0;
        #1;
        check_output("midreset_x", int'(x), 318);
        check_output("midreset_y", int'(y), 450);
        check_output("midreset_active", int'(ball_active), 0);
        check_output("midreset_lost", int'(lost), 0);
        model_reset();
        @(negedge clk); nRst = 1'b1;
        cycle(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 0, 0, 0, 0, 0, 0, 0);
        quiet_frame(1);
        repeat (3) cycle(0, 1, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_output("queue_drained", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Parametrised successor to the single-ball mover.
- Holds one ball's fixed-point position and signed velocity, and latches collision flags during the frame.
- Applies reflection, including corner double-flips, at each frame boundary.
- Adds serve/lost game states and paddle-hit speed-up. Sits between the collision detector and the sprite renderer; the renderer reads x/y, the game controller reads lost/ball_active.

Parameters:
X_WIDTH, 10, integer pixel width of x.
Y_WIDTH, 9, integer pixel width of y.
FRAC_BITS, 1, fractional bits in internal position and velocity (velocity unit = 2^-FRAC_BITS px/frame).
VEL_WIDTH, 4, signed velocity register width.
INITIAL_X, 318, serve x in pixels.
INITIAL_Y, 450, serve y in pixels.
INITIAL_VEL_X, 2, serve x velocity (signed, fractional units).
INITIAL_VEL_Y, -2, serve y velocity (signed, fractional units).
MAX_SPEED, 6, cap on |vel_y|; must be at most 2^(VEL_WIDTH-1)-1.
SPEEDUP_HITS, 4, paddle hits per speed-up step; must be at least 1.
LOST_Y, 470, integer y at or above which the ball is lost.

Ports:
clk  in  1  system clock
nRst  in  1  asynchronous active-low reset
frame_pulse  in  1  one-cycle pulse at end of frame
do_move  in  1  motion enable (pause when 0)
serve  in  1  serve request, level or pulse
collision  in  1  ball overlaps an object this cycle
ball_top_col  in  1  ball top edge hit
ball_bottom_col  in  1  ball bottom edge hit
ball_left_col  in  1  ball left edge hit
ball_right_col  in  1  ball right edge hit
paddle_col  in  1  the current collision is with the paddle
x  out  X_WIDTH  integer ball x
y  out  Y_WIDTH  integer ball y
ball_active  out  1  1 in MOVING state
lost  out  1  one-cycle pulse when ball is lost

Behaviour:
- Reset (asynchronous, active-low, any time including mid-frame):
  - State = SERVE; position = INITIAL_X/INITIAL_Y, with fractional bits = 0.
  - vel = INITIAL_VEL_X/INITIAL_VEL_Y; hit counter = 0; all latches = 0; serve_pending = 0.
  - Outputs: x=INITIAL_X, y=INITIAL_Y, ball_active=0, lost=0.
- x and y are the integer bits of the internal position; fractional bits are dropped. Outputs are registered and have no combinational path from inputs.
- Collision latches: latch_any, latch_v (top|bottom), latch_h (left|right), latch_pad.
  - On a frame_pulse cycle, all latches clear. A collision in that same cycle is dropped.
  - Otherwise, when collision=1, each latch ORs in its input.
- serve_pending: set when serve=1 in SERVE state; cleared on leaving SERVE.
- States:
  - SERVE:
    - Position is held at the initial values; latches are ignored.
    - On frame_pulse with serve_pending, or with serve=1 in that cycle: go to MOVING and reload vel to the initial values.
  - MOVING: update only on frame_pulse && do_move, using the latches from before the clear:
    - If latch_v: vel_y is negated.
    - If latch_h: vel_x is negated.
    - If both latch_v and latch_h (corner hit): both are negated.
    - The step uses the post-reflection velocity: pos += sign-extended new vel, with two's-complement wrap at the full register width.
    - If latch_pad is set: the hit counter increments. When it reaches SPEEDUP_HITS, it returns to 0 and |vel_y| increases by 1, sign kept, saturating at MAX_SPEED. The speed-up takes effect on the following frame's step.
    - Lost check: if the post-step integer y >= LOST_Y, and the step did not wrap, go to LOST.
    - frame_pulse with do_move=0: no motion, but the latches still clear.
  - LOST:
    - lost=1 for exactly the first cycle in LOST.
    - On the next frame_pulse: go to SERVE and reload position and velocity; the hit counter resets.
- Negating the most-negative velocity value is illegal by parameter choice; no check is made.

Test Plan:
- Reset then release; no serve over 3 frame pulses -> x=318, y=450, ball_active=0 throughout.
- serve pulse, then 1 frame pulse, then 1 more frame pulse with do_move=1 -> ball_active=1; internal pos +2/-2 half-px, so x=319, y=449.
- Moving; collision with ball_top_col mid-frame, then frame_pulse -> vel_y becomes +2, y +1 px. Collision in the same cycle as frame_pulse -> ignored.
- Corner: top and left asserted on separate cycles of one frame -> both velocities negate; ball moves diagonally back.
- 4 frames each carrying a paddle bottom hit -> after the 4th frame |vel_y|=3. After a further 12 hits, vel_y stays at 6 (saturated).
- Drive ball to y>=470 -> lost high for exactly 1 cycle. Next frame_pulse -> SERVE, x/y restored, counter 0. Assert nRst mid-MOVING -> immediate return to reset values.
